// File: rtl/aes_encipher_word_serial.sv
// Word-serial AES-128/256 encipher round engine.
// SubBytes goes through one shared 32-bit S-box port, one state word per cycle.
module aes_encipher_word_serial (
    input  logic         clk,
    input  logic         reset,
    input  logic         next,
    input  logic         keylen,
    output logic [3:0]   round,
    input  logic [127:0] round_key,
    input  logic [127:0] block,
    output logic [31:0]  sboxw,
    input  logic [31:0]  new_sboxw,
    output logic [127:0] new_block,
    output logic         ready
);
    localparam int unsigned BLOCK_W = 128;
    localparam int unsigned WORD_W  = 32;
    localparam int unsigned RND_W   = 4;
    localparam int unsigned SWORD_W = 2;
    localparam logic [RND_W-1:0] NR_128 = RND_W'(10);
    localparam logic [RND_W-1:0] NR_256 = RND_W'(14);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_INIT,
        ST_SBOX,
        ST_MAIN
    } state_t;

    state_t               state, state_nxt;
    logic [BLOCK_W-1:0]   block_reg, block_nxt;
    logic [RND_W-1:0]     round_ctr, round_nxt;
    logic [RND_W-1:0]     nr_reg, nr_nxt;
    logic [SWORD_W-1:0]   sword_ctr, sword_nxt;
    logic                 ready_reg, ready_nxt;
    logic [WORD_W-1:0]    cur_word;
    logic [BLOCK_W-1:0]   shifted;
    logic [BLOCK_W-1:0]   mixed;

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [31:0] mix_word(input logic [31:0] w);
        logic [7:0] b0, b1, b2, b3;
        {b0, b1, b2, b3} = w;
        return {xtime(b0) ^ xtime(b1) ^ b1 ^ b2 ^ b3,
                b0 ^ xtime(b1) ^ xtime(b2) ^ b2 ^ b3,
                b0 ^ b1 ^ xtime(b2) ^ xtime(b3) ^ b3,
                xtime(b0) ^ b0 ^ b1 ^ b2 ^ xtime(b3)};
    endfunction

    // Output word c, byte r takes input word (c+r) mod 4, byte r.
    function automatic logic [127:0] shift_rows(input logic [127:0] s);
        return {s[127:120], s[87:80],   s[47:40],   s[7:0],
                s[95:88],   s[55:48],   s[15:8],    s[103:96],
                s[63:56],   s[23:16],   s[111:104], s[71:64],
                s[31:24],   s[119:112], s[79:72],   s[39:32]};
    endfunction

    assign shifted = shift_rows(block_reg);
    assign mixed   = {mix_word(shifted[127:96]), mix_word(shifted[95:64]),
                      mix_word(shifted[63:32]),  mix_word(shifted[31:0])};

    always_comb begin
        cur_word = block_reg[127:96];
        case (sword_ctr)
            2'd0: cur_word = block_reg[127:96];
            2'd1: cur_word = block_reg[95:64];
            2'd2: cur_word = block_reg[63:32];
            2'd3: cur_word = block_reg[31:0];
        endcase
    end

    assign sboxw     = (state == ST_SBOX) ? cur_word : block_reg[127:96];
    assign new_block = block_reg;
    assign round     = round_ctr;
    assign ready     = ready_reg;

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ST_IDLE;
            block_reg <= '0;
            round_ctr <= '0;
            nr_reg    <= NR_128;
            sword_ctr <= '0;
            ready_reg <= 1'b1;
        end else begin
            state     <= state_nxt;
            block_reg <= block_nxt;
            round_ctr <= round_nxt;
            nr_reg    <= nr_nxt;
            sword_ctr <= sword_nxt;
            ready_reg <= ready_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        block_nxt = block_reg;
        round_nxt = round_ctr;
        nr_nxt    = nr_reg;
        sword_nxt = sword_ctr;
        ready_nxt = ready_reg;
        case (state)
            ST_IDLE: begin
                if (next) begin
                    nr_nxt    = keylen ? NR_256 : NR_128;
                    round_nxt = '0;
                    ready_nxt = 1'b0;
                    state_nxt = ST_INIT;
                end
            end
            ST_INIT: begin
                block_nxt = block ^ round_key;
                round_nxt = RND_W'(1);
                sword_nxt = '0;
                state_nxt = ST_SBOX;
            end
            ST_SBOX: begin
                case (sword_ctr)
                    2'd0: block_nxt[127:96] = new_sboxw;
                    2'd1: block_nxt[95:64]  = new_sboxw;
                    2'd2: block_nxt[63:32]  = new_sboxw;
                    2'd3: block_nxt[31:0]   = new_sboxw;
                endcase
                sword_nxt = sword_ctr + SWORD_W'(1);
                if (sword_ctr == SWORD_W'(3)) begin
                    state_nxt = ST_MAIN;
                end
            end
            ST_MAIN: begin
                if (round_ctr == nr_reg) begin
                    block_nxt = shifted ^ round_key;
                    ready_nxt = 1'b1;
                    state_nxt = ST_IDLE;
                end else begin
                    block_nxt = mixed ^ round_key;
                    round_nxt = round_ctr + RND_W'(1);
                    state_nxt = ST_SBOX;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end
endmodule

// File: tb/tb_aes_encipher_word_serial.sv
// Bench for aes_encipher_word_serial: FIPS-197 vectors, random blocks, busy/reset robustness.
// The bench supplies the S-box and round keys and holds a byte-level AES reference.
module tb_aes_encipher_word_serial;
    logic         clk = 1'b0;
    logic         reset;
    logic         next;
    logic         keylen;
    logic [3:0]   round;
    logic [127:0] round_key;
    logic [127:0] block;
    logic [31:0]  sboxw;
    logic [31:0]  new_sboxw;
    logic [127:0] new_block;
    logic         ready;

    logic [7:0]   sbox [0:255];
    logic [127:0] rk   [0:15];
    logic [127:0] pre  [0:15];
    logic [127:0] mct;
    int           n_assert = 0;
    int           n_fail   = 0;

    aes_encipher_word_serial dut (
        .clk       (clk),
        .reset     (reset),
        .next      (next),
        .keylen    (keylen),
        .round     (round),
        .round_key (round_key),
        .block     (block),
        .sboxw     (sboxw),
        .new_sboxw (new_sboxw),
        .new_block (new_block),
        .ready     (ready)
    );

    always #5 clk = ~clk;

    assign round_key = rk[round];
    assign new_sboxw = {sbox[sboxw[31:24]], sbox[sboxw[23:16]], sbox[sboxw[15:8]], sbox[sboxw[7:0]]};

    function automatic logic [7:0] xt(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, x, y;
        p = 8'h00;
        x = a;
        y = b;
        for (int i = 0; i < 8; i++) begin
            if (y[0]) p = p ^ x;
            x = xt(x);
            y = y >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] x, input int k);
        return (x << k) | (x >> (8 - k));
    endfunction

    function automatic logic [31:0] subword(input logic [31:0] w);
        return {sbox[w[31:24]], sbox[w[23:16]], sbox[w[15:8]], sbox[w[7:0]]};
    endfunction

    // S-box from its definition: GF(2^8) inverse followed by the affine map.
    task automatic build_sbox();
        logic [7:0] inv;
        for (int a = 0; a < 256; a++) begin
            inv = 8'h00;
            for (int c = 1; c < 256; c++)
                if (gmul(8'(a), 8'(c)) == 8'h01) inv = 8'(c);
            sbox[a] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
        end
    endtask

    // Key schedule plus byte-array reference; records the state entering each SubBytes.
    task automatic prepare(input logic [255:0] key, input bit kl, input logic [127:0] pt);
        logic [31:0] w [0:59];
        logic [7:0]  s [0:15];
        logic [7:0]  t [0:15];
        logic [7:0]  a0, a1, a2, a3, rc;
        logic [31:0] tmp;
        logic [127:0] v;
        int nk, nr, nw;
        nk = kl ? 8 : 4;
        nr = kl ? 14 : 10;
        nw = 4 * (nr + 1);
        for (int i = 0; i < nk; i++) w[i] = key[255 - 32*i -: 32];
        rc = 8'h01;
        for (int i = nk; i < nw; i++) begin
            tmp = w[i-1];
            if (i % nk == 0) begin
                tmp = subword({tmp[23:0], tmp[31:24]}) ^ {rc, 24'h0};
                rc  = xt(rc);
            end else if (nk == 8 && i % nk == 4) begin
                tmp = subword(tmp);
            end
            w[i] = w[i-nk] ^ tmp;
        end
        for (int r = 0; r < 16; r++) begin
            rk[r]  = '0;
            pre[r] = '0;
        end
        for (int r = 0; r <= nr; r++) rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
        for (int k = 0; k < 16; k++) s[k] = pt[127 - 8*k -: 8] ^ rk[0][127 - 8*k -: 8];
        for (int r = 1; r <= nr; r++) begin
            for (int k = 0; k < 16; k++) v[127 - 8*k -: 8] = s[k];
            pre[r] = v;
            for (int k = 0; k < 16; k++) s[k] = sbox[s[k]];
            for (int c = 0; c < 4; c++)
                for (int b = 0; b < 4; b++)
                    t[4*c + b] = s[4*((c + b) % 4) + b];
            for (int c = 0; c < 4; c++) begin
                a0 = t[4*c]; a1 = t[4*c+1]; a2 = t[4*c+2]; a3 = t[4*c+3];
                if (r < nr) begin
                    s[4*c]   = gmul(8'h02, a0) ^ gmul(8'h03, a1) ^ a2 ^ a3;
                    s[4*c+1] = a0 ^ gmul(8'h02, a1) ^ gmul(8'h03, a2) ^ a3;
                    s[4*c+2] = a0 ^ a1 ^ gmul(8'h02, a2) ^ gmul(8'h03, a3);
                    s[4*c+3] = gmul(8'h03, a0) ^ a1 ^ a2 ^ gmul(8'h02, a3);
                end else begin
                    s[4*c] = a0; s[4*c+1] = a1; s[4*c+2] = a2; s[4*c+3] = a3;
                end
            end
            for (int k = 0; k < 16; k++) s[k] = s[k] ^ rk[r][127 - 8*k -: 8];
        end
        for (int k = 0; k < 16; k++) v[127 - 8*k -: 8] = s[k];
        mct = v;
    endtask

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Leaves the bench at the falling edge right after the start edge E0.
    task automatic start(input bit kl, input logic [127:0] pt, input bit hold);
        @(negedge clk);
        keylen = kl;
        block  = pt;
        next   = 1'b1;
        @(posedge clk);
        @(negedge clk);
        if (!hold) next = 1'b0;
    endtask

    // Cycle n is observed just after edge En; expectations follow from the round timing.
    task automatic run_check(input string tag, input int nr, input logic [127:0] exp_ct, input bit perturb);
        int last, hits, r, j, er;
        logic [127:0] ew;
        last = 5*nr + 1;
        hits = 0;
        for (int n = 0; n <= last; n++) begin
            if (n > 0) @(negedge clk);
            er = (n == 0) ? 0 : (((n - 1) / 5 + 1 > nr) ? nr : (n - 1) / 5 + 1);
            check({tag, " round"}, 128'(round), 128'(er));
            if (n < last) begin
                check({tag, " ready_busy"}, 128'(ready), 128'(1'b0));
                if (n >= 1 && (n - 1) % 5 < 4) begin
                    r  = (n - 1) / 5 + 1;
                    j  = (n - 1) % 5;
                    ew = 128'(pre[r][127 - 32*j -: 32]);
                    if (128'(sboxw) === ew) hits++;
                    check({tag, " sboxw"}, 128'(sboxw), ew);
                end
            end else begin
                check({tag, " ready_done"}, 128'(ready), 128'(1'b1));
                check({tag, " ciphertext"}, new_block, exp_ct);
            end
            if (perturb && n == 7) begin
                next   = 1'b1;
                keylen = ~keylen;
            end
            if (perturb && n == 9) begin
                next   = 1'b0;
                keylen = ~keylen;
            end
        end
        check({tag, " lookups"}, 128'(hits), 128'(4*nr));
    endtask

    localparam logic [255:0] KEY_B  = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
    localparam logic [255:0] KEY_C1 = {128'h000102030405060708090a0b0c0d0e0f, 128'h0};
    localparam logic [255:0] KEY_C3 = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
    localparam logic [127:0] PT_B   = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] PT_C   = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] CT_B   = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] CT_C1  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] CT_C3  = 128'h8ea2b7ca516745bfeafc49904b496089;

    initial begin
        logic [255:0] rkey;
        logic [127:0] rpt;
        bit           rkl;

        reset  = 1'b1;
        next   = 1'b0;
        keylen = 1'b0;
        block  = '0;
        build_sbox();
        prepare(KEY_C1, 1'b0, PT_C);
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset ready", 128'(ready), 128'(1'b1));
        check("reset round", 128'(round), 128'(0));
        check("reset new_block", new_block, 128'(0));
        check("reset sboxw", 128'(sboxw), 128'(0));
        reset = 1'b0;

        prepare(KEY_B, 1'b0, PT_B);
        start(1'b0, PT_B, 1'b0);
        run_check("fips_b", 10, CT_B, 1'b0);

        prepare(KEY_C1, 1'b0, PT_C);
        start(1'b0, PT_C, 1'b0);
        run_check("fips_c1", 10, CT_C1, 1'b0);

        prepare(KEY_C3, 1'b1, PT_C);
        start(1'b1, PT_C, 1'b0);
        run_check("fips_c3", 14, CT_C3, 1'b0);

        prepare(KEY_C1, 1'b0, PT_C);
        start(1'b0, PT_C, 1'b0);
        run_check("busy_perturb", 10, CT_C1, 1'b1);
        @(negedge clk);
        check("busy_no_restart", 128'(ready), 128'(1'b1));

        // next held high across two back-to-back runs
        start(1'b0, PT_C, 1'b1);
        run_check("hold_run1", 10, CT_C1, 1'b0);
        prepare(KEY_C3, 1'b1, PT_C);
        keylen = 1'b1;
        @(negedge clk);
        run_check("hold_run2", 14, CT_C3, 1'b0);
        next = 1'b0;
        @(negedge clk);
        check("hold_idle", 128'(ready), 128'(1'b1));

        // reset in the SBOX phase of round 5, with a competing start request
        prepare(KEY_C1, 1'b0, PT_C);
        start(1'b0, PT_C, 1'b0);
        repeat (22) @(negedge clk);
        reset = 1'b1;
        next  = 1'b1;
        @(negedge clk);
        check("midrst ready", 128'(ready), 128'(1'b1));
        check("midrst round", 128'(round), 128'(0));
        check("midrst new_block", new_block, 128'(0));
        check("midrst sboxw", 128'(sboxw), 128'(0));
        reset = 1'b0;
        next  = 1'b0;
        start(1'b0, PT_C, 1'b0);
        run_check("after_rst", 10, CT_C1, 1'b0);

        for (int it = 0; it < 4; it++) begin
            rkey = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
            rpt  = {$urandom, $urandom, $urandom, $urandom};
            rkl  = 1'($urandom_range(1, 0));
            if (!rkl) rkey[127:0] = '0;
            prepare(rkey, rkl, rpt);
            start(rkl, rpt, 1'b0);
            run_check("random", rkl ? 14 : 10, mct, 1'b0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
